// File: rtl/mmio_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mmio_arb_pkg                                                     |
// | Purpose : Shared types and helpers for the MMIO memory arbiter.            |
// |           - arb_state_t : arbiter FSM states (IDLE / ISSUE / RESP)         |
// |           - ERR_RDATA   : read data returned on a watchdog timeout         |
// |           - grant_w()   : width of a requester index                       |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package mmio_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_t;

   // Wide enough for any supported data width; users slice the low bits.
   localparam logic [1023:0] ERR_RDATA = '1;

   // Index width for n requesters; never narrower than one bit.
   function automatic int grant_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_mem_arbiter_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_picker                                                        |
// | Purpose : Combinational round-robin find-first. Searches req starting at   |
// |           last_grant+1 with wrap-around and returns the first set index.   |
// | Ports   : req        in  N_REQ  request vector                             |
// |           last_grant in  GW     index granted most recently                |
// |           winner     out GW     selected index (0 when nothing found)      |
// |           found      out 1      at least one request is set                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module rr_picker
   import mmio_arb_pkg::*;
#(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0]          req,
   input  logic [grant_w(N_REQ)-1:0] last_grant,
   output logic [grant_w(N_REQ)-1:0] winner,
   output logic                      found
);

   localparam int GW = grant_w(N_REQ);

   // Walk offsets from farthest to nearest so the nearest set request after
   // last_grant is the final (winning) assignment.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int k = N_REQ; k >= 1; k--) begin
         if (req[(int'(last_grant) + k) % N_REQ]) begin
            winner = GW'((int'(last_grant) + k) % N_REQ);
            found  = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mmio_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : mmio_mem_arbiter                                                 |
// | Purpose : Round-robin arbiter sharing one MMIO memory port between N_REQ   |
// |           requesters. One transaction at a time: latch winner command,     |
// |           drive it downstream until mem_ack, pulse resp_valid to winner.   |
// | Ports   : clk, rst (async, active-high)                                    |
// |           req_valid/we/addr/wdata/wmask  packed per-requester commands     |
// |           resp_valid/rdata/err           per-requester completion          |
// |           mem_req/we/addr/wdata/wmask, mem_ack/rdata  downstream port      |
// |           busy, grant_id                 status                            |
// | Options : define ARB_TIMEOUT_EN to enable the ISSUE watchdog               |
// |           (TIMEOUT_CYCLES); otherwise ISSUE waits forever, resp_err = 0.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module mmio_mem_arbiter
   import mmio_arb_pkg::*;
#(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int N_REQ          = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [N_REQ-1:0]              req_we,
   input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
   input  logic [N_REQ*DATA_WIDTH/8-1:0] req_wmask,
   output logic [N_REQ-1:0]              resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_rdata,
   output logic                          resp_err,
   output logic                          mem_req,
   output logic                          mem_we,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_wdata,
   output logic [DATA_WIDTH/8-1:0]       mem_wmask,
   input  logic                          mem_ack,
   input  logic [DATA_WIDTH-1:0]         mem_rdata,
   output logic                          busy,
   output logic [grant_w(N_REQ)-1:0]     grant_id
);

   localparam int GW = grant_w(N_REQ);
   localparam int MW = DATA_WIDTH / 8;

   if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("mmio_mem_arbiter: unsupported parameter value");
   end

   arb_state_t            state;
   arb_state_t            state_next;
   logic [GW-1:0]         last_grant;
   logic [GW-1:0]         pick;
   logic                  found;
   logic                  cmd_we;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [MW-1:0]         cmd_wmask;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  timeout_hit;

   rr_picker #(
      .N_REQ(N_REQ)
   ) u_picker (
      .req        (req_valid),
      .last_grant (last_grant),
      .winner     (pick),
      .found      (found)
   );

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] wd_cnt;
   logic          err_q;

   // Held at zero outside ISSUE, so it reads 0 in the first ISSUE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  wd_cnt <= '0;
      else if (state != ISSUE)  wd_cnt <= '0;
      else                      wd_cnt <= wd_cnt + 1'b1;
   end

   // A same-cycle ack takes precedence over the limit.
   assign timeout_hit = (state == ISSUE) && !mem_ack
                        && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  err_q <= 1'b0;
      else if (state == ISSUE)  err_q <= timeout_hit;
   end

   assign resp_err = (state == RESP) && err_q;
`else
   assign timeout_hit = 1'b0;
   assign resp_err    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      mem_req    = 1'b0;
      resp_valid = '0;
      case (state)
         IDLE: begin
            if (found) state_next = ISSUE;
         end
         ISSUE: begin
            mem_req = 1'b1;
            if (mem_ack || timeout_hit) state_next = RESP;
         end
         RESP: begin
            resp_valid[grant_id] = 1'b1;
            state_next           = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Command latch and response data. Requester inputs are only looked at
   // in IDLE, so the granted requester is free to change them afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant <= GW'(N_REQ - 1);
         grant_id   <= '0;
         cmd_we     <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
         cmd_wmask  <= '0;
         rdata_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  grant_id   <= pick;
                  last_grant <= pick;
                  cmd_we     <= req_we[pick];
                  cmd_addr   <= req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                  cmd_wdata  <= req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
                  cmd_wmask  <= req_wmask[pick*MW +: MW];
               end
            end
            ISSUE: begin
               if (mem_ack)
                  rdata_q <= cmd_we ? '0 : mem_rdata;
               else if (timeout_hit)
                  rdata_q <= ERR_RDATA[DATA_WIDTH-1:0];
            end
            default: ;
         endcase
      end
   end

   assign mem_we     = cmd_we;
   assign mem_addr   = cmd_addr;
   assign mem_wdata  = cmd_wdata;
   assign mem_wmask  = cmd_wmask;
   assign resp_rdata = rdata_q;
   assign busy       = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mmio_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_mmio_mem_arbiter                                              |
// | Purpose : Self-checking bench for mmio_mem_arbiter (N_REQ=2, 64-bit,       |
// |           TIMEOUT_CYCLES=16). Directed steps followed by random traffic    |
// |           checked against a round-robin reference model.                   |
// | Options : ARB_TIMEOUT_EN adds the watchdog steps.                          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mmio_mem_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;
   localparam int MW = DW / 8;
   localparam int N  = 2;
   localparam int TO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N*MW-1:0] req_wmask;
   logic [N-1:0]    resp_valid;
   logic [DW-1:0]   resp_rdata;
   logic            resp_err;
   logic            mem_req;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [MW-1:0]   mem_wmask;
   logic            mem_ack;
   logic [DW-1:0]   mem_rdata;
   logic            busy;
   logic [0:0]      grant_id;

   always #5 clk = ~clk;

   mmio_mem_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_REQ(N), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wmask(req_wmask),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .busy(busy), .grant_id(grant_id)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Requester-side view: pending flags and each requester's command.
   logic [N-1:0]  pend;
   logic          cwe[N];
   logic [AW-1:0] caddr[N];
   logic [DW-1:0] cwdata[N];
   logic [MW-1:0] cmask[N];
   int            last;      // model: most recently served requester
   logic [DW-1:0] last_rd;   // model: last returned read data

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]            = pend[i];
         req_we[i]               = cwe[i];
         req_addr[i*AW +: AW]    = caddr[i];
         req_wdata[i*DW +: DW]   = cwdata[i];
         req_wmask[i*MW +: MW]   = cmask[i];
      end
   endtask

   task automatic new_cmd(input int i);
      cwe[i]    = 1'($urandom_range(0, 1));
      caddr[i]  = {$urandom, $urandom};
      cwdata[i] = {$urandom, $urandom};
      cmask[i]  = MW'($urandom);
   endtask

   // Round-robin rule: first pending requester after the last one served.
   function automatic int model_pick(input logic [N-1:0] p, input int lst);
      for (int k = 1; k <= N; k++)
         if (p[(lst + k) % N]) return (lst + k) % N;
      return -1;
   endfunction

   // Runs one transaction from an IDLE cycle whose inputs are already driven.
   task automatic do_txn(input int delay, input logic [DW-1:0] rd, input int keep);
      int            w;
      logic [N-1:0]  exp_rv;
      logic [DW-1:0] exp_rd;
      w = model_pick(pend, last);
      tick();
      check("issue_mem_req", mem_req, 1);
      check("issue_busy", busy, 1);
      check("grant_id", grant_id, w);
      check("mem_we", mem_we, cwe[w]);
      check("mem_addr", mem_addr, caddr[w]);
      check("mem_wdata", mem_wdata, cwdata[w]);
      check("mem_wmask", mem_wmask, cmask[w]);
      last = w;
      for (int c = 0; c < delay; c++) begin
         tick();
         check("hold_mem_req", mem_req, 1);
         check("hold_mem_addr", mem_addr, caddr[w]);
         check("hold_mem_wdata", mem_wdata, cwdata[w]);
         check("hold_resp_valid", resp_valid, 0);
      end
      mem_ack   = 1'b1;
      mem_rdata = rd;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = {$urandom, $urandom};
      exp_rv    = '0;
      exp_rv[w] = 1'b1;
      exp_rd    = cwe[w] ? '0 : rd;
      check("resp_valid", resp_valid, exp_rv);
      check("resp_rdata", resp_rdata, exp_rd);
      check("resp_err", resp_err, 0);
      check("resp_mem_req", mem_req, 0);
      last_rd = exp_rd;
      if (keep != 0) new_cmd(w);
      else           pend[w] = 1'b0;
      drive();
      tick();
      check("idle_busy", busy, 0);
      check("idle_resp_valid", resp_valid, 0);
      check("idle_rdata_hold", resp_rdata, last_rd);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      rst       = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      pend      = '0;
      for (int i = 0; i < N; i++) new_cmd(i);
      drive();
      last      = N - 1;
      last_rd   = '0;
      tick();
      tick();
      // Reset state
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_rdata", resp_rdata, 0);
      check("rst_resp_err", resp_err, 0);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_wmask", mem_wmask, 0);
      check("rst_busy", busy, 0);
      check("rst_grant_id", grant_id, 0);
      rst = 1'b0;
      tick();

      // Single read, ack in the second ISSUE cycle
      pend      = 2'b01;
      cwe[0]    = 1'b0;
      caddr[0]  = 64'h0000_0000_0200_BFF8;
      drive();
      do_txn(1, 64'h1234, 0);

      // Reset while a transaction is in ISSUE
      pend = 2'b01;
      new_cmd(0);
      drive();
      tick();
      check("pre_rst_mem_req", mem_req, 1);
      #1 rst = 1'b1;
      #1;
      check("async_rst_mem_req", mem_req, 0);
      check("async_rst_busy", busy, 0);
      check("async_rst_resp_valid", resp_valid, 0);
      pend = 2'b11;
      new_cmd(1);
      drive();
      tick();
      rst  = 1'b0;
      last = N - 1;

      // Contention with immediate acks: grant order 0,1,0,1
      do_txn(0, {$urandom, $urandom}, 1);
      do_txn(0, {$urandom, $urandom}, 1);
      do_txn(0, {$urandom, $urandom}, 1);
      do_txn(0, {$urandom, $urandom}, 0);
      pend = '0;
      drive();
      tick();
      check("post_cont_busy", busy, 0);

      // Masked write from requester 1
      pend      = 2'b10;
      cwe[1]    = 1'b1;
      caddr[1]  = 64'h0000_0000_0200_4000;
      cwdata[1] = 64'h0000_0000_DEAD_BEEF;
      cmask[1]  = 8'h0F;
      drive();
      do_txn(2, 64'h5555_AAAA_5555_AAAA, 0);

      // Requester 1 pulses valid for one cycle while requester 0 is in flight
      pend     = 2'b01;
      cwe[0]   = 1'b0;
      caddr[0] = {$urandom, $urandom};
      drive();
      tick();
      check("wd_grant", grant_id, 0);
      last = 0;
      pend[1] = 1'b1;
      new_cmd(1);
      drive();
      tick();
      pend[1] = 1'b0;
      drive();
      mem_ack   = 1'b1;
      mem_rdata = 64'h0BAD_F00D;
      tick();
      mem_ack = 1'b0;
      check("wd_resp_valid", resp_valid, 2'b01);
      check("wd_rdata", resp_rdata, 64'h0BAD_F00D);
      last_rd = 64'h0BAD_F00D;
      pend = '0;
      drive();
      for (int c = 0; c < 3; c++) begin
         tick();
         check("wd_no_mem_req", mem_req, 0);
         check("wd_no_resp", resp_valid, 0);
      end

      // mem_ack while IDLE is ignored
      mem_ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("stray_ack_busy", busy, 0);
         check("stray_ack_resp", resp_valid, 0);
         check("stray_ack_rdata", resp_rdata, last_rd);
      end
      mem_ack = 1'b0;

`ifdef ARB_TIMEOUT_EN
      // Watchdog expiry: 16 ISSUE cycles, then an error response
      pend   = 2'b01;
      cwe[0] = 1'b0;
      drive();
      tick();
      last = 0;
      for (int c = 0; c < TO; c++) begin
         check("to_mem_req_hold", mem_req, 1);
         tick();
      end
      check("to_mem_req_drop", mem_req, 0);
      check("to_resp_valid", resp_valid, 2'b01);
      check("to_resp_err", resp_err, 1);
      check("to_resp_rdata", resp_rdata, {DW{1'b1}});
      last_rd = {DW{1'b1}};
      pend = '0;
      drive();
      mem_ack = 1'b1;
      tick();
      tick();
      mem_ack = 1'b0;
      check("to_late_ack_busy", busy, 0);
      check("to_late_ack_resp", resp_valid, 0);
      check("to_err_cleared", resp_err, 0);

      // Ack in the same cycle as the limit wins
      pend = 2'b01;
      drive();
      tick();
      for (int c = 0; c < TO - 1; c++) tick();
      mem_ack   = 1'b1;
      mem_rdata = 64'hABCD;
      tick();
      mem_ack = 1'b0;
      check("to_edge_resp_valid", resp_valid, 2'b01);
      check("to_edge_resp_err", resp_err, 0);
      check("to_edge_rdata", resp_rdata, 64'hABCD);
      last_rd = 64'hABCD;
      pend = '0;
      drive();
      tick();
`endif

      // Random traffic against the round-robin model
      for (int t = 0; t < 60; t++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(0, 2) != 0) begin
               pend[i] = 1'b1;
               new_cmd(i);
            end
         drive();
         if (pend == '0) begin
            tick();
            check("rnd_idle_busy", busy, 0);
            check("rnd_idle_rdata", resp_rdata, last_rd);
         end else begin
            do_txn(int'($urandom_range(0, 3)), {$urandom, $urandom},
                   int'($urandom_range(0, 1)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
